// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Purpose  : Raster pixel stream to 3x3 window stream (two line buffers).
// Revision : 1.0  initial release
// ============================================================================
module sobel_window_gen #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] pixel_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [7:0] p0_o,
   output logic [7:0] p1_o,
   output logic [7:0] p2_o,
   output logic [7:0] p3_o,
   output logic [7:0] p4_o,
   output logic [7:0] p5_o,
   output logic [7:0] p6_o,
   output logic [7:0] p7_o,
   output logic [7:0] p8_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       eof_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
   localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              valid_q, valid_d;
   logic              eof_q, eof_d;
   logic [8:0][7:0]   win_q, win_d;
   // [2:0] = older column (top,mid,bot), [5:3] = newer column
   logic [5:0][7:0]   sr_q, sr_d;

   logic [7:0]        lb0_mem [IMG_W];
   logic [7:0]        lb1_mem [IMG_W];
   logic [7:0]        lb0_rd, lb1_rd;
   logic              in_xfer, produce, last_pix;

   assign ready_o  = !valid_q || ready_i;
   assign in_xfer  = valid_i && ready_o;
   assign produce  = in_xfer && (row_q >= c_ROW_TWO) && (col_q >= c_COL_TWO);
   assign last_pix = (row_q == c_ROW_LAST) && (col_q == c_COL_LAST);
   assign lb0_rd   = lb0_mem[col_q];
   assign lb1_rd   = lb1_mem[col_q];

   // Line buffers carry no reset so they map onto RAM; row gating hides stale data
   always_ff @(posedge clk_i) begin
      if (in_xfer) begin
         lb0_mem[col_q] <= lb1_rd;
         lb1_mem[col_q] <= pixel_i;
      end
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      valid_d = valid_q;
      eof_d   = eof_q;
      win_d   = win_q;
      sr_d    = sr_q;
      if (in_xfer) begin
         if (col_q == c_COL_LAST) begin
            col_d = '0;
            row_d = (row_q == c_ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         sr_d[2:0] = sr_q[5:3];
         sr_d[3]   = lb0_rd;
         sr_d[4]   = lb1_rd;
         sr_d[5]   = pixel_i;
      end
      if (produce) begin
         win_d[0] = sr_q[0];
         win_d[1] = sr_q[3];
         win_d[2] = lb0_rd;
         win_d[3] = sr_q[1];
         win_d[4] = sr_q[4];
         win_d[5] = lb1_rd;
         win_d[6] = sr_q[2];
         win_d[7] = sr_q[5];
         win_d[8] = pixel_i;
         valid_d  = 1'b1;
         eof_d    = last_pix;
      end else if (ready_i) begin
         valid_d = 1'b0;
         eof_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         eof_q   <= 1'b0;
         win_q   <= '0;
         sr_q    <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         eof_q   <= eof_d;
         win_q   <= win_d;
         sr_q    <= sr_d;
      end
   end

   assign valid_o = valid_q;
   assign eof_o   = eof_q;
   assign p0_o    = win_q[0];
   assign p1_o    = win_q[1];
   assign p2_o    = win_q[2];
   assign p3_o    = win_q[3];
   assign p4_o    = win_q[4];
   assign p5_o    = win_q[5];
   assign p6_o    = win_q[6];
   assign p7_o    = win_q[7];
   assign p8_o    = win_q[8];

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_gen
// Purpose  : Directed self-checking bench for sobel_window_gen on a 4x4 image.
// Revision : 1.0  initial release
// ============================================================================
module tb_sobel_window_gen;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int NWIN = (W - 2) * (H - 2);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pixel_i = '0;
   logic       valid_i = 1'b0;
   logic       ready_i = 1'b1;
   logic       ready_o, valid_o, eof_o;
   logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

   int n_checks = 0;
   int n_pass   = 0;
   bit rand_rdy = 1'b0;
   logic [72:0] cap_q[$];

   always #5 clk = ~clk;

   sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .pixel_i(pixel_i), .valid_i(valid_i),
      .ready_o(ready_o),
      .p0_o(p0), .p1_o(p1), .p2_o(p2), .p3_o(p3), .p4_o(p4),
      .p5_o(p5), .p6_o(p6), .p7_o(p7), .p8_o(p8),
      .valid_o(valid_o), .ready_i(ready_i), .eof_o(eof_o)
   );

   function automatic logic [72:0] cur_win();
      return {eof_o, p0, p1, p2, p3, p4, p5, p6, p7, p8};
   endfunction

   // Window k of a frame: centre at (2 + k/(W-2) - 1, 2 + k%(W-2) - 1)
   function automatic logic [72:0] exp_win(input int k, input int off);
      logic [72:0] w;
      int r, c;
      r = 2 + k / (W - 2);
      c = 2 + k % (W - 2);
      w = '0;
      w[72] = (k == NWIN - 1);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[71 - 8*(3*i + j) -: 8] = 8'(16*(r - 2 + i) + (c - 2 + j) + off);
      return w;
   endfunction

   always @(negedge clk)
      if (rst_n && valid_o && ready_i) cap_q.push_back(cur_win());

   task automatic idle_cycle();
      valid_i = 1'b0;
      @(posedge clk); #1;
      if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic send_pixel(input logic [7:0] v);
      bit ok;
      ok = 1'b0;
      pixel_i = v;
      valid_i = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = ready_o;
         @(posedge clk); #1;
         if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
      end
      valid_i = 1'b0;
      if (!ok) begin
         n_checks++;
         $display("FAIL send_pixel: pixel %h not accepted, ready_o=%b required 1", v, ready_o);
      end
   endtask

   task automatic send_range(input int first, input int count, input int off, input bit gaps);
      for (int n = first; n < first + count; n++) begin
         if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
         send_pixel(8'(16*(n / W) + (n % W) + off));
      end
   endtask

   task automatic drain();
      rand_rdy = 1'b0;
      ready_i  = 1'b1;
      valid_i  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      rand_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cap_q.delete();
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({valid_o, eof_o, ready_o} !== 3'b001)
         $display("FAIL reset_ctrl: valid/eof/ready=%b required 001", {valid_o, eof_o, ready_o});
      else n_pass++;
      n_checks++;
      if (cur_win() !== 73'd0) $display("FAIL reset_taps: got %h required 0", cur_win());
      else n_pass++;
      do_reset();
   endtask

   task automatic test_continuous();
      do_reset();
      send_range(0, W*H, 0, 1'b0);
      drain();
      n_checks++;
      if (cap_q.size() !== NWIN)
         $display("FAIL cont_count: got %0d windows required %0d", cap_q.size(), NWIN);
      else n_pass++;
      for (int k = 0; k < NWIN && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_win(k, 0))
            $display("FAIL cont_win%0d: got %h required %h", k, cap_q[k], exp_win(k, 0));
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      ready_i = 1'b0;
      send_range(0, 2*W + 3, 0, 1'b0);
      pixel_i = 8'h23;
      valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({valid_o, ready_o} !== 2'b10 || cur_win() !== exp_win(0, 0))
            $display("FAIL bp_hold%0d: valid/ready=%b win=%h required 10 %h",
                     i, {valid_o, ready_o}, cur_win(), exp_win(0, 0));
         else n_pass++;
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      send_range(2*W + 3, W*H - (2*W + 3), 0, 1'b0);
      drain();
      n_checks++;
      if (cap_q.size() !== NWIN)
         $display("FAIL bp_count: got %0d windows required %0d", cap_q.size(), NWIN);
      else n_pass++;
      for (int k = 0; k < NWIN && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_win(k, 0))
            $display("FAIL bp_win%0d: got %h required %h", k, cap_q[k], exp_win(k, 0));
         else n_pass++;
      end
   endtask

   task automatic test_reset_held();
      do_reset();
      ready_i = 1'b0;
      send_range(0, 2*W + 3, 0, 1'b0);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({valid_o, eof_o, ready_o} !== 3'b001 || cur_win() !== 73'd0)
         $display("FAIL async_reset: valid/eof/ready=%b win=%h required 001 0",
                  {valid_o, eof_o, ready_o}, cur_win());
      else n_pass++;
      do_reset();
   endtask

   task automatic test_random_gaps();
      int eofs;
      do_reset();
      rand_rdy = 1'b1;
      send_range(0, W*H, 0, 1'b1);
      drain();
      n_checks++;
      if (cap_q.size() !== NWIN)
         $display("FAIL rnd_count: got %0d windows required %0d", cap_q.size(), NWIN);
      else n_pass++;
      eofs = 0;
      for (int k = 0; k < cap_q.size(); k++) eofs += int'(cap_q[k][72]);
      n_checks++;
      if (eofs !== 1) $display("FAIL rnd_eof: got %0d eof windows required 1", eofs);
      else n_pass++;
      for (int k = 0; k < NWIN && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_win(k, 0))
            $display("FAIL rnd_win%0d: got %h required %h", k, cap_q[k], exp_win(k, 0));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_range(0, W*H, 0, 1'b0);
      send_range(0, W*H, 8'h80, 1'b0);
      drain();
      n_checks++;
      if (cap_q.size() !== 2*NWIN)
         $display("FAIL b2b_count: got %0d windows required %0d", cap_q.size(), 2*NWIN);
      else n_pass++;
      for (int k = 0; k < 2*NWIN && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_win(k % NWIN, (k < NWIN) ? 0 : 8'h80))
            $display("FAIL b2b_win%0d: got %h required %h", k, cap_q[k],
                     exp_win(k % NWIN, (k < NWIN) ? 0 : 8'h80));
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      send_range(0, 2*W + 2, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({valid_o, ready_o} !== 2'b01)
            $display("FAIL mid_reset%0d: valid/ready=%b required 01", i, {valid_o, ready_o});
         else n_pass++;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cap_q.delete();
      send_range(0, W*H, 0, 1'b0);
      drain();
      n_checks++;
      if (cap_q.size() !== NWIN)
         $display("FAIL mr_count: got %0d windows required %0d", cap_q.size(), NWIN);
      else n_pass++;
      for (int k = 0; k < NWIN && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_win(k, 0))
            $display("FAIL mr_win%0d: got %h required %h", k, cap_q[k], exp_win(k, 0));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_backpressure();
      test_reset_held();
      test_random_gaps();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
